// File: rtl/ula_seq_pkg.sv
// Shared definitions for the sequential ALU: default widths, opcode
// encodings, flag bit positions and the FSM / engine enumerations.
package ula_seq_pkg;

  localparam int DATA_WIDTH_DEF   = 16;
  localparam int OPCODE_WIDTH_DEF = 4;
  localparam int RFLAGS_WIDTH_DEF = 5;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_CMP = 2;
  localparam int OP_MUL = 3;
  localparam int OP_DIV = 4;
  localparam int OP_AND = 5;
  localparam int OP_OR  = 6;
  localparam int OP_NOT = 7;

  localparam int FLAG_DIVZ = 0;
  localparam int FLAG_LT   = 1;
  localparam int FLAG_EQ   = 2;
  localparam int FLAG_GT   = 3;
  localparam int FLAG_OVF  = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  typedef enum logic {
    ENG_MUL,
    ENG_DIV
  } eng_mode_t;

endpackage

// File: rtl/ula_seq_if.sv
// Request/response bundle between the control FSM (master) and the
// sequential ALU (slave).
interface ula_seq_if
  import ula_seq_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF,
  parameter int RFLAGS_WIDTH = RFLAGS_WIDTH_DEF
);
  logic                           start;
  logic        [OPCODE_WIDTH-1:0] opcode;
  logic signed [DATA_WIDTH-1:0]   data1;
  logic signed [DATA_WIDTH-1:0]   data2;
  logic                           busy;
  logic                           done;
  logic signed [DATA_WIDTH-1:0]   out;
  logic signed [DATA_WIDTH-1:0]   rem;
  logic        [RFLAGS_WIDTH-1:0] rflags;

  modport master (
    output start, opcode, data1, data2,
    input  busy, done, out, rem, rflags
  );

  modport slave (
    input  start, opcode, data1, data2,
    output busy, done, out, rem, rflags
  );
endinterface

// File: rtl/ula_iter_core.sv
// Unsigned iterative engine: W-step shift-add multiply or restoring divide.
// hi/lo hold the product (hi:lo) or remainder (hi) and quotient (lo).
module ula_iter_core
  import ula_seq_pkg::*;
#(
  parameter int W = DATA_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         go,
  input  eng_mode_t    mode,
  input  logic [W-1:0] a_mag,
  input  logic [W-1:0] b_mag,
  output logic [W-1:0] prod_hi,
  output logic [W-1:0] prod_lo,
  output logic [W-1:0] quo,
  output logic [W-1:0] rmd,
  output logic         fin
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  hi, lo, b_r;
  eng_mode_t     mode_r;
  logic          run;
  logic [CW-1:0] cnt;
  logic [W:0]    add_sum, sh;
  logic [W-1:0]  sub_res;
  logic          ge;

  // Per-step arithmetic for both algorithms
  always_comb begin
    add_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_r} : '0);
    sh      = {hi, lo[W-1]};
    ge      = sh >= {1'b0, b_r};
    sub_res = sh[W-1:0] - b_r;
  end

  assign fin     = run && (cnt == CW'(W - 1));
  assign prod_hi = hi;
  assign prod_lo = lo;
  assign quo     = lo;
  assign rmd     = hi;

  // Load on go, then one shift/add or shift/subtract step per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi     <= '0;
      lo     <= '0;
      b_r    <= '0;
      mode_r <= ENG_MUL;
      run    <= 1'b0;
      cnt    <= '0;
    end else if (go) begin
      hi     <= '0;
      lo     <= a_mag;
      b_r    <= b_mag;
      mode_r <= mode;
      run    <= 1'b1;
      cnt    <= '0;
    end else if (run) begin
      if (mode_r == ENG_DIV) begin
        if (ge) begin
          hi <= sub_res;
          lo <= {lo[W-2:0], 1'b1};
        end else begin
          hi <= sh[W-1:0];
          lo <= {lo[W-2:0], 1'b0};
        end
      end else begin
        hi <= add_sum[W:1];
        lo <= {add_sum[0], lo[W-1:1]};
      end
      cnt <= cnt + CW'(1);
      if (fin) run <= 1'b0;
    end
  end
endmodule

// File: rtl/ula_seq.sv
// Sequential ALU top: start/busy/done handshake FSM, single-cycle ops,
// sign handling around the iterative MUL/DIV engine, and flag generation.
module ula_seq
  import ula_seq_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF,
  parameter int RFLAGS_WIDTH = RFLAGS_WIDTH_DEF
) (
  input logic      clk,
  input logic      rst_n,
  ula_seq_if.slave bus
);
  localparam int W = DATA_WIDTH;
  localparam logic [OPCODE_WIDTH-1:0] C_ADD = OPCODE_WIDTH'(OP_ADD);
  localparam logic [OPCODE_WIDTH-1:0] C_SUB = OPCODE_WIDTH'(OP_SUB);
  localparam logic [OPCODE_WIDTH-1:0] C_CMP = OPCODE_WIDTH'(OP_CMP);
  localparam logic [OPCODE_WIDTH-1:0] C_MUL = OPCODE_WIDTH'(OP_MUL);
  localparam logic [OPCODE_WIDTH-1:0] C_DIV = OPCODE_WIDTH'(OP_DIV);
  localparam logic [OPCODE_WIDTH-1:0] C_AND = OPCODE_WIDTH'(OP_AND);
  localparam logic [OPCODE_WIDTH-1:0] C_OR  = OPCODE_WIDTH'(OP_OR);
  localparam logic [OPCODE_WIDTH-1:0] C_NOT = OPCODE_WIDTH'(OP_NOT);

  state_t                   state, state_nxt;
  logic                     accept, long_op, is_div, div_zero, go, fin;
  eng_mode_t                mode;
  logic        [W-1:0]      a_mag, b_mag, p_hi, p_lo, quo, rmd;
  logic                     div_r, neg_r, sa_r;
  logic signed [W-1:0]      out_r, rem_r;
  logic [RFLAGS_WIDTH-1:0]  flags_r;
  logic signed [W-1:0]      b_eff, sum, sc_out;
  logic [RFLAGS_WIDTH-1:0]  sc_flags;
  logic                     sc_ovf;
  logic signed [2*W-1:0]    prod_s;

  function automatic logic [W-1:0] mag(input logic signed [W-1:0] x);
    return x[W-1] ? -x : x;
  endfunction

  function automatic logic signed [W-1:0] apply_sign(input logic [W-1:0] m, input logic neg);
    return neg ? -m : m;
  endfunction

  // True when the signed 2W product is representable in W bits
  function automatic logic fits_w(input logic signed [2*W-1:0] p);
    return (p[2*W-1:W-1] == '0) || (p[2*W-1:W-1] == '1);
  endfunction

  assign is_div   = bus.opcode == C_DIV;
  assign div_zero = is_div && (bus.data2 == '0);
  assign long_op  = (bus.opcode == C_MUL) || (is_div && !div_zero);
  // A request is taken in IDLE and also in the DONE cycle for back-to-back use
  assign accept   = bus.start && ((state == S_IDLE) || (state == S_DONE));
  assign go       = accept && long_op;
  assign mode     = is_div ? ENG_DIV : ENG_MUL;
  assign a_mag    = mag(bus.data1);
  assign b_mag    = mag(bus.data2);
  assign prod_s   = neg_r ? -{p_hi, p_lo} : {p_hi, p_lo};

  ula_iter_core #(.W(W)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (go),
    .mode    (mode),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .prod_hi (p_hi),
    .prod_lo (p_lo),
    .quo     (quo),
    .rmd     (rmd),
    .fin     (fin)
  );

  // Handshake state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: short ops go straight to DONE, long ops iterate then fix signs
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: state_nxt = accept ? (long_op ? S_ITER : S_DONE) : S_IDLE;
      S_ITER:         if (fin) state_nxt = S_FIX;
      S_FIX:          state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle result and flags; SUB/CMP add the two's-complement negation
  always_comb begin
    b_eff    = ((bus.opcode == C_SUB) || (bus.opcode == C_CMP)) ? -bus.data2 : bus.data2;
    sum      = bus.data1 + b_eff;
    sc_ovf   = (bus.data1[W-1] == b_eff[W-1]) && (sum[W-1] != bus.data1[W-1]);
    sc_out   = bus.data1;
    sc_flags = '0;
    case (bus.opcode)
      C_ADD, C_SUB: begin
        sc_out             = sum;
        sc_flags[FLAG_OVF] = sc_ovf;
      end
      C_CMP: begin
        sc_out             = sum;
        sc_flags[FLAG_OVF] = sc_ovf;
        sc_flags[FLAG_EQ]  = (sum == '0);
        sc_flags[FLAG_GT]  = !sum[W-1] && (sum != '0);
        sc_flags[FLAG_LT]  = sum[W-1];
      end
      C_AND:   sc_out = bus.data1 & bus.data2;
      C_OR:    sc_out = bus.data1 | bus.data2;
      C_NOT:   sc_out = (bus.data1 == '0) ? W'(1) : '0;
      C_DIV:   sc_flags[FLAG_DIVZ] = 1'b1;
      default: ;
    endcase
  end

  // Result registers: loaded on a short accept or in FIX, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r   <= '0;
      rem_r   <= '0;
      flags_r <= '0;
      div_r   <= 1'b0;
      neg_r   <= 1'b0;
      sa_r    <= 1'b0;
    end else begin
      if (go) begin
        div_r <= is_div;
        neg_r <= bus.data1[W-1] ^ bus.data2[W-1];
        sa_r  <= bus.data1[W-1];
      end
      if (accept && !long_op) begin
        out_r   <= sc_out;
        rem_r   <= '0;
        flags_r <= sc_flags;
      end else if (state == S_FIX) begin
        flags_r <= '0;
        if (div_r) begin
          // Only MIN / -1 yields a positive quotient magnitude of 2^(W-1)
          out_r             <= apply_sign(quo, neg_r);
          rem_r             <= apply_sign(rmd, sa_r);
          flags_r[FLAG_OVF] <= !neg_r && quo[W-1];
        end else begin
          out_r             <= prod_s[W-1:0];
          rem_r             <= '0;
          flags_r[FLAG_OVF] <= !fits_w(prod_s);
        end
      end
    end
  end

  assign bus.busy   = state != S_IDLE;
  assign bus.done   = state == S_DONE;
  assign bus.out    = out_r;
  assign bus.rem    = rem_r;
  assign bus.rflags = flags_r;
endmodule

// File: tb/tb_ula_seq.sv
// Bench for ula_seq: arithmetic reference model, per-cycle compare against
// it, directed literal cases, then randomized traffic.
module tb_ula_seq;
  import ula_seq_pkg::*;

  localparam int W        = 16;
  localparam int LONG_LAT = W + 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ula_seq_if #(.DATA_WIDTH(W), .OPCODE_WIDTH(4), .RFLAGS_WIDTH(5)) bus ();

  ula_seq #(.DATA_WIDTH(W), .OPCODE_WIDTH(4), .RFLAGS_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] o;
    logic [15:0] r;
    logic [4:0]  f;
    int          lat;
  } res_t;

  int   total = 0;
  int   bad   = 0;
  bit   pending = 1'b0;
  bit   m_acc;
  int   cyc = 0;
  int   done_cyc = 0;
  res_t pend, held;
  int   r_op, dones, first_done;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [15:0] lo16(input longint v);
    return v[15:0];
  endfunction

  function automatic logic out16(input longint v);
    return (v > 32767) || (v < -32768);
  endfunction

  // Expected result of one operation from plain signed arithmetic
  function automatic res_t model(input int op, input logic [15:0] d1, input logic [15:0] d2);
    res_t   x;
    longint a, b, nb, s;
    a     = longint'($signed(d1));
    b     = longint'($signed(d2));
    x.o   = d1;
    x.r   = 16'h0;
    x.f   = 5'h0;
    x.lat = 1;
    case (op)
      OP_ADD: begin
        s = a + b;
        x.o = lo16(s);
        x.f[4] = out16(s);
      end
      OP_SUB, OP_CMP: begin
        nb = (b == -32768) ? -32768 : -b;
        s = a + nb;
        x.o = lo16(s);
        x.f[4] = out16(s);
        if (op == OP_CMP) begin
          x.f[2] = (x.o == 16'h0);
          x.f[3] = ($signed(x.o) > 0);
          x.f[1] = ($signed(x.o) < 0);
        end
      end
      OP_MUL: begin
        s = a * b;
        x.o = lo16(s);
        x.f[4] = out16(s);
        x.lat = LONG_LAT;
      end
      OP_DIV: begin
        if (b == 0) begin
          x.f[0] = 1'b1;
        end else if (a == -32768 && b == -1) begin
          x.o = 16'h8000;
          x.f[4] = 1'b1;
          x.lat = LONG_LAT;
        end else begin
          x.o = lo16(a / b);
          x.r = lo16(a % b);
          x.lat = LONG_LAT;
        end
      end
      OP_AND:  x.o = d1 & d2;
      OP_OR:   x.o = d1 | d2;
      OP_NOT:  x.o = (d1 == 16'h0) ? 16'h1 : 16'h0;
      default: ;
    endcase
    return x;
  endfunction

  function automatic logic [15:0] rnd_word();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'h0001;
      2:       return 16'hFFFF;
      3:       return 16'h8000;
      4:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Model timeline: which request is in flight and what is visible each cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending = 1'b0;
      held.o  = 16'h0;
      held.r  = 16'h0;
      held.f  = 5'h0;
    end else begin
      m_acc = (bus.start === 1'b1) && (!pending || cyc == done_cyc);
      if (pending && cyc == done_cyc) pending = 1'b0;
      if (m_acc) begin
        pend     = model(int'(bus.opcode), bus.data1, bus.data2);
        pending  = 1'b1;
        done_cyc = cyc + pend.lat;
      end
      cyc++;
      if (pending && cyc == done_cyc) held = pend;
    end
  end

  // Every cycle out of reset: handshake and held outputs against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("done",   16'(bus.done),   16'(pending && cyc == done_cyc));
      chk("busy",   16'(bus.busy),   16'(pending));
      chk("out",    bus.out,         held.o);
      chk("rem",    bus.rem,         held.r);
      chk("rflags", 16'(bus.rflags), 16'(held.f));
    end
  end

  task automatic run_op(input string nm, input int op, input logic [15:0] d1, input logic [15:0] d2,
                        input logic [15:0] eo, input logic [15:0] er, input logic [4:0] ef,
                        input int elat, input bit b2b);
    int waited;
    if (!b2b) @(negedge clk);
    bus.start  = 1'b1;
    bus.opcode = 4'(op);
    bus.data1  = d1;
    bus.data2  = d2;
    @(negedge clk);
    bus.start = 1'b0;
    waited = 1;
    while (bus.done !== 1'b1 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    chk({nm, "_lat"},   16'(waited),     16'(elat));
    chk({nm, "_out"},   bus.out,         eo);
    chk({nm, "_rem"},   bus.rem,         er);
    chk({nm, "_flags"}, 16'(bus.rflags), 16'(ef));
  endtask

  initial begin
    held.o = 16'h0;
    held.r = 16'h0;
    held.f = 5'h0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.opcode = '0;
    bus.data1  = '0;
    bus.data2  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  16'(bus.busy),   16'h0);
    chk("rst_done",  16'(bus.done),   16'h0);
    chk("rst_out",   bus.out,         16'h0);
    chk("rst_flags", 16'(bus.rflags), 16'h0);
    #2 rst_n = 1'b1;

    run_op("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 16'h0, 5'h10, 1, 1'b0);
    run_op("add",     OP_ADD, 16'h0005, 16'hFFFD, 16'h0002, 16'h0, 5'h00, 1, 1'b0);
    run_op("cmp_lt",  OP_CMP, 16'h0003, 16'h0007, 16'hFFFC, 16'h0, 5'h02, 1, 1'b0);
    run_op("cmp_eq",  OP_CMP, 16'h0007, 16'h0007, 16'h0000, 16'h0, 5'h04, 1, 1'b0);
    run_op("cmp_gt",  OP_CMP, 16'h0009, 16'h0002, 16'h0007, 16'h0, 5'h08, 1, 1'b0);
    run_op("cmp_min", OP_CMP, 16'h8000, 16'h0001, 16'h7FFF, 16'h0, 5'h18, 1, 1'b0);
    run_op("mul_ovf", OP_MUL, 16'hFED4, 16'h00C8, 16'h15A0, 16'h0, 5'h10, 18, 1'b0);
    run_op("mul",     OP_MUL, 16'hFFF4, 16'h000B, 16'hFF7C, 16'h0, 5'h00, 18, 1'b0);
    run_op("div_b2b", OP_DIV, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 5'h00, 18, 1'b1);
    run_op("div_z",   OP_DIV, 16'h0005, 16'h0000, 16'h0005, 16'h0, 5'h01, 1, 1'b0);
    run_op("div_min", OP_DIV, 16'h8000, 16'hFFFF, 16'h8000, 16'h0, 5'h10, 18, 1'b0);
    run_op("not0",    OP_NOT, 16'h0000, 16'h1234, 16'h0001, 16'h0, 5'h00, 1, 1'b0);
    run_op("and_b2b", OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0, 5'h00, 1, 1'b1);
    run_op("unk",     15,     16'h1234, 16'h0001, 16'h1234, 16'h0, 5'h00, 1, 1'b0);

    // Starts during a MUL are dropped; exactly one done at cycle 18
    @(negedge clk);
    bus.start  = 1'b1;
    bus.opcode = 4'(OP_MUL);
    bus.data1  = 16'hFED4;
    bus.data2  = 16'h00C8;
    @(negedge clk);
    bus.start  = 1'b0;
    dones      = 0;
    first_done = 0;
    for (int c = 1; c <= 25; c++) begin
      if (bus.done === 1'b1) begin
        dones++;
        if (first_done == 0) first_done = c;
      end
      bus.start = (c == 3 || c == 10);
      if (c == 3 || c == 10) begin
        bus.opcode = 4'(OP_ADD);
        bus.data1  = 16'h0001;
        bus.data2  = 16'h0001;
      end
      @(negedge clk);
    end
    chk("ign_dones", 16'(dones),      16'd1);
    chk("ign_cycle", 16'(first_done), 16'd18);

    // Reset in cycle 8 of a DIV clears outputs at once and cancels the op
    bus.start  = 1'b1;
    bus.opcode = 4'(OP_DIV);
    bus.data1  = 16'h0064;
    bus.data2  = 16'h0007;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",  16'(bus.busy),   16'h0);
    chk("arst_done",  16'(bus.done),   16'h0);
    chk("arst_out",   bus.out,         16'h0);
    chk("arst_rem",   bus.rem,         16'h0);
    chk("arst_flags", 16'(bus.rflags), 16'h0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    chk("arst_nodone", 16'(dones), 16'd0);
    run_op("post_rst", OP_DIV, 16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 5'h00, 18, 1'b0);

    // Random traffic, including starts while busy and in the DONE cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 99) < 40);
      r_op = $urandom_range(0, 9);
      if (r_op > 7) r_op = 15;
      bus.opcode = 4'(r_op);
      bus.data1  = rnd_word();
      bus.data2  = rnd_word();
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (25) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
